// File: rtl/spi_slave_rx_if.sv
// spi_slave_rx_if: SPI receive pins plus the received-byte output bundle.
interface spi_slave_rx_if;
    logic       spi_sclk_in;
    logic       spi_mosi_in;
    logic       spi_cs_n_in;
    logic       spi_dc_in;
    logic       dc_out;
    logic       byte_rdy_out;
    logic [7:0] byte_data_out;
    modport master (
        output spi_sclk_in, spi_mosi_in, spi_cs_n_in, spi_dc_in,
        input  dc_out, byte_rdy_out, byte_data_out
    );
    modport slave (
        input  spi_sclk_in, spi_mosi_in, spi_cs_n_in, spi_dc_in,
        output dc_out, byte_rdy_out, byte_data_out
    );
endinterface

// File: rtl/spi_slave_rx.sv
// spi_slave_rx: mode-0 SPI byte receiver with D/C capture, oversampled by clk_in.
module spi_slave_rx #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic          clk_in,
    input  logic          rst_n_in,
    spi_slave_rx_if.slave bus
);
    logic       sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic       mosi_s1_q, mosi_s2_q;
    logic       cs_s1_q, cs_s2_q;
    logic       dc_s1_q, dc_s2_q;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d, shift_nx;
    logic [7:0] data_q, data_d;
    logic       dc_q, dc_d, rdy_q, rdy_d;
    logic       sample, done;

    always_comb begin
        sample   = sclk_s2_q & ~sclk_s3_q & ~cs_s2_q;
        shift_nx = MSB_FIRST ? {shift_q[6:0], mosi_s2_q} : {mosi_s2_q, shift_q[7:1]};
        done     = sample & (cnt_q == 3'd7);
        cnt_d    = cs_s2_q ? 3'd0 : sample ? cnt_q + 3'd1 : cnt_q;
        shift_d  = cs_s2_q ? 8'h00 : sample ? shift_nx : shift_q;
        data_d   = done ? shift_nx : data_q;
        dc_d     = done ? dc_s2_q : dc_q;
        rdy_d    = done;
    end

    // CS_n synchronizer resets to 1 so nothing is sampled right after reset release
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sclk_s1_q <= 1'b0;
            sclk_s2_q <= 1'b0;
            sclk_s3_q <= 1'b0;
            mosi_s1_q <= 1'b0;
            mosi_s2_q <= 1'b0;
            cs_s1_q   <= 1'b1;
            cs_s2_q   <= 1'b1;
            dc_s1_q   <= 1'b0;
            dc_s2_q   <= 1'b0;
            cnt_q     <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            dc_q      <= 1'b0;
            rdy_q     <= 1'b0;
        end else begin
            sclk_s1_q <= bus.spi_sclk_in;
            sclk_s2_q <= sclk_s1_q;
            sclk_s3_q <= sclk_s2_q;
            mosi_s1_q <= bus.spi_mosi_in;
            mosi_s2_q <= mosi_s1_q;
            cs_s1_q   <= bus.spi_cs_n_in;
            cs_s2_q   <= cs_s1_q;
            dc_s1_q   <= bus.spi_dc_in;
            dc_s2_q   <= dc_s1_q;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            dc_q      <= dc_d;
            rdy_q     <= rdy_d;
        end
    end

    assign bus.byte_data_out = data_q;
    assign bus.dc_out        = dc_q;
    assign bus.byte_rdy_out  = rdy_q;
endmodule
